// File: rtl/hazard_stall_ctrl.sv
// Hazard sequencer beside ID: load-use / branch-operand stalls, branch/jump flush, DMEM freeze.
// Optional HAZARD_PERF_EN builds saturating stall/flush performance counters.
module hazard_stall_ctrl #(
  parameter int LU_STALLS     = 1,
  parameter int BR_ALU_STALLS = 1,
  parameter int BR_LD_STALLS  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ID_RegRs,
  input  logic [4:0]  ID_RegRt,
  input  logic        ID_UsesRt,
  input  logic        ID_Branch,
  input  logic        ID_BranchTaken,
  input  logic        ID_Jump,
  input  logic        EX_MemRead,
  input  logic        EX_RegWrite,
  input  logic [4:0]  EX_WriteReg,
  input  logic        MEM_MemRead,
  input  logic [4:0]  MEM_WriteReg,
  input  logic        DMEM_Busy,
  output logic        PC_Write,
  output logic        IFID_Write,
  output logic        IFID_Flush,
  output logic        IDEX_Bubble,
  output logic        Pipe_Freeze,
  output logic [1:0]  Stall_Cnt,
  output logic [31:0] Perf_StallCycles,
  output logic [31:0] Perf_Flushes
);

  typedef enum logic [1:0] {RUN, STALL, FREEZE} state_t;

  state_t     state, saved_state, eff_state;
  logic [1:0] cnt;
  logic [2:0] n;
  logic       ex_match, mem_match, hazard, stall, flush;

  function automatic logic src_match(input logic [4:0] r);
    return (r != 5'd0) && ((r == ID_RegRs) || (ID_UsesRt && (r == ID_RegRt)));
  endfunction

  assign ex_match  = src_match(EX_WriteReg);
  assign mem_match = src_match(MEM_WriteReg);

  // Largest required bubble count among all hazards that apply this cycle
  always_comb begin
    n = 3'd0;
    if (EX_MemRead && ex_match && (3'(LU_STALLS) > n))
      n = 3'(LU_STALLS);
    if (ID_Branch && EX_MemRead && ex_match && (3'(BR_LD_STALLS) > n))
      n = 3'(BR_LD_STALLS);
    if (ID_Branch && MEM_MemRead && mem_match && (3'd1 > n))
      n = 3'd1;
    if (ID_Branch && EX_RegWrite && !EX_MemRead && ex_match && (3'(BR_ALU_STALLS) > n))
      n = 3'(BR_ALU_STALLS);
  end

  // After a freeze the pipe behaves exactly as the state it was frozen in
  assign eff_state = (state == FREEZE) ? saved_state : state;
  assign hazard    = (eff_state == RUN) && (n != 3'd0);
  assign stall     = !DMEM_Busy && ((eff_state == STALL) || hazard);
  assign flush     = !DMEM_Busy && (eff_state == RUN) && !hazard &&
                     (ID_Jump || (ID_Branch && ID_BranchTaken));

  always_comb begin
    PC_Write    = 1'b1;
    IFID_Write  = 1'b1;
    IFID_Flush  = 1'b0;
    IDEX_Bubble = 1'b0;
    Pipe_Freeze = 1'b0;
    if (!reset) begin
      PC_Write    = !DMEM_Busy && !stall;
      IFID_Write  = !DMEM_Busy && !stall;
      IFID_Flush  = flush;
      IDEX_Bubble = stall;
      Pipe_Freeze = DMEM_Busy;
    end
  end

  assign Stall_Cnt = cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      saved_state <= RUN;
      cnt         <= 2'd0;
    end else if (DMEM_Busy) begin
      state       <= FREEZE;
      saved_state <= eff_state;
    end else begin
      case (eff_state)
        STALL: begin
          if (cnt <= 2'd1) begin
            state <= RUN;
            cnt   <= 2'd0;
          end else begin
            state <= STALL;
            cnt   <= cnt - 2'd1;
          end
        end
        default: begin
          if (hazard && (n > 3'd1)) begin
            state <= STALL;
            cnt   <= 2'(n - 3'd1);
          end else begin
            state <= RUN;
            cnt   <= 2'd0;
          end
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles, flushes;

  // stall/flush are already suppressed while the pipe is frozen
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= 32'd0;
      flushes      <= 32'd0;
    end else begin
      if (stall && (stall_cycles != 32'hFFFF_FFFF))
        stall_cycles <= stall_cycles + 32'd1;
      if (flush && (flushes != 32'hFFFF_FFFF))
        flushes <= flushes + 32'd1;
    end
  end

  assign Perf_StallCycles = stall_cycles;
  assign Perf_Flushes     = flushes;
`else
  assign Perf_StallCycles = 32'd0;
  assign Perf_Flushes     = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed + randomized bench for hazard_stall_ctrl against a "bubbles still owed" reference model.
module tb_hazard_stall_ctrl;
  localparam int LU = 1, BR_ALU = 1, BR_LD = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  ID_RegRs, ID_RegRt, EX_WriteReg, MEM_WriteReg;
  logic        ID_UsesRt, ID_Branch, ID_BranchTaken, ID_Jump;
  logic        EX_MemRead, EX_RegWrite, MEM_MemRead, DMEM_Busy;
  logic        PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, Pipe_Freeze;
  logic [1:0]  Stall_Cnt;
  logic [31:0] Perf_StallCycles, Perf_Flushes;

  int checks = 0;
  int failures = 0;
  int pending = 0;
  logic [31:0] m_stalls = 0, m_flushes = 0;

  hazard_stall_ctrl #(.LU_STALLS(LU), .BR_ALU_STALLS(BR_ALU), .BR_LD_STALLS(BR_LD)) dut (
    .clk(clk), .reset(reset),
    .ID_RegRs(ID_RegRs), .ID_RegRt(ID_RegRt), .ID_UsesRt(ID_UsesRt),
    .ID_Branch(ID_Branch), .ID_BranchTaken(ID_BranchTaken), .ID_Jump(ID_Jump),
    .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite), .EX_WriteReg(EX_WriteReg),
    .MEM_MemRead(MEM_MemRead), .MEM_WriteReg(MEM_WriteReg), .DMEM_Busy(DMEM_Busy),
    .PC_Write(PC_Write), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
    .IDEX_Bubble(IDEX_Bubble), .Pipe_Freeze(Pipe_Freeze), .Stall_Cnt(Stall_Cnt),
    .Perf_StallCycles(Perf_StallCycles), .Perf_Flushes(Perf_Flushes)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit reads(input logic [4:0] r);
    return r != 0 && (r == ID_RegRs || (ID_UsesRt && r == ID_RegRt));
  endfunction

  // Bubbles demanded by the instruction in ID given the current EX/MEM contents
  function automatic int needed();
    int k = 0;
    if (EX_MemRead && reads(EX_WriteReg)) k = (LU > k) ? LU : k;
    if (ID_Branch && EX_MemRead && reads(EX_WriteReg)) k = (BR_LD > k) ? BR_LD : k;
    if (ID_Branch && MEM_MemRead && reads(MEM_WriteReg)) k = (1 > k) ? 1 : k;
    if (ID_Branch && EX_RegWrite && !EX_MemRead && reads(EX_WriteReg)) k = (BR_ALU > k) ? BR_ALU : k;
    return k;
  endfunction

  task automatic set_in(input int rs, input int rt, input bit ut, input bit br, input bit tk,
                        input bit jmp, input bit exmr, input bit exrw, input int exwr,
                        input bit memmr, input int memwr, input bit busy);
    ID_RegRs = 5'(rs); ID_RegRt = 5'(rt); ID_UsesRt = ut; ID_Branch = br;
    ID_BranchTaken = tk; ID_Jump = jmp; EX_MemRead = exmr; EX_RegWrite = exrw;
    EX_WriteReg = 5'(exwr); MEM_MemRead = memmr; MEM_WriteReg = 5'(memwr); DMEM_Busy = busy;
  endtask

  task automatic check_perf(input string tag);
`ifdef HAZARD_PERF_EN
    chk({tag, ".perf_stall"}, Perf_StallCycles, m_stalls);
    chk({tag, ".perf_flush"}, Perf_Flushes, m_flushes);
`else
    chk({tag, ".perf_stall"}, Perf_StallCycles, 32'd0);
    chk({tag, ".perf_flush"}, Perf_Flushes, 32'd0);
`endif
  endtask

  // Check one cycle mid-period, then advance the model across the edge
  task automatic run_cycle(input string tag);
    bit e_frz, e_bub, e_fl;
    int nxt, k;
    @(negedge clk);
    e_frz = DMEM_Busy; e_bub = 0; e_fl = 0; nxt = pending;
    if (!DMEM_Busy) begin
      if (pending > 0) begin
        e_bub = 1; nxt = pending - 1;
      end else begin
        k = needed();
        if (k > 0) begin
          e_bub = 1; nxt = k - 1;
        end else begin
          e_fl = ID_Jump || (ID_Branch && ID_BranchTaken);
        end
      end
    end
    chk({tag, ".pc_write"}, 32'(PC_Write), 32'(!e_frz && !e_bub));
    chk({tag, ".ifid_write"}, 32'(IFID_Write), 32'(!e_frz && !e_bub));
    chk({tag, ".ifid_flush"}, 32'(IFID_Flush), 32'(e_fl));
    chk({tag, ".idex_bubble"}, 32'(IDEX_Bubble), 32'(e_bub));
    chk({tag, ".pipe_freeze"}, 32'(Pipe_Freeze), 32'(e_frz));
    chk({tag, ".stall_cnt"}, 32'(Stall_Cnt), 32'(pending));
    check_perf(tag);
    $display("cycle %-12s busy=%0b bubble=%0b flush=%0b cnt=%0d", tag, DMEM_Busy,
             IDEX_Bubble, IFID_Flush, Stall_Cnt);
    @(posedge clk);
    #1;
    pending = nxt;
    if (e_bub && m_stalls != 32'hFFFF_FFFF) m_stalls++;
    if (e_fl && m_flushes != 32'hFFFF_FFFF) m_flushes++;
  endtask

  initial begin
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("rst.pc_write", 32'(PC_Write), 32'd1);
    chk("rst.ifid_write", 32'(IFID_Write), 32'd1);
    chk("rst.bubble", 32'(IDEX_Bubble), 32'd0);
    chk("rst.flush", 32'(IFID_Flush), 32'd0);
    chk("rst.freeze", 32'(Pipe_Freeze), 32'd0);
    chk("rst.stall_cnt", 32'(Stall_Cnt), 32'd0);
    check_perf("rst");
    #10 reset = 1'b0;
    @(posedge clk); #1;

    // load-use: lw $2 in EX, add uses $2
    set_in(2, 0, 0, 0, 0, 0, 1, 1, 2, 0, 0, 0); run_cycle("lu_detect");
    set_in(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0); run_cycle("lu_after");
    // beq rs=3 behind lw $3: two bubbles, then taken branch flushes
    set_in(3, 4, 1, 1, 0, 0, 1, 1, 3, 0, 0, 0); run_cycle("bld_detect");
    set_in(3, 4, 1, 1, 0, 0, 0, 0, 0, 1, 3, 0); run_cycle("bld_stall");
    set_in(3, 4, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0); run_cycle("bld_resolve");
    // beq rt=5 behind ALU write of $5, then $0 destination
    set_in(1, 5, 1, 1, 0, 0, 0, 1, 5, 0, 0, 0); run_cycle("bal");
    set_in(1, 5, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0); run_cycle("bal_r0");
    set_in(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0); run_cycle("jump");
    // DMEM busy for 3 cycles inside a 2-cycle branch stall
    set_in(3, 4, 1, 1, 0, 0, 1, 1, 3, 0, 0, 0); run_cycle("frz_detect");
    for (int i = 0; i < 3; i++) begin
      set_in(3, 4, 1, 1, 0, 0, 0, 0, 0, 1, 3, 1); run_cycle("frz_busy");
    end
    set_in(3, 4, 1, 1, 0, 0, 0, 0, 0, 1, 3, 0); run_cycle("frz_resume");
    set_in(3, 4, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0); run_cycle("frz_done");
    // async reset in the middle of a stall
    set_in(3, 4, 1, 1, 0, 0, 1, 1, 3, 0, 0, 0); run_cycle("rs_detect");
    set_in(3, 4, 1, 1, 0, 0, 0, 0, 0, 1, 3, 0);
    #2 reset = 1'b1;
    #1;
    pending = 0; m_stalls = 0; m_flushes = 0;
    chk("rs_mid.pc_write", 32'(PC_Write), 32'd1);
    chk("rs_mid.bubble", 32'(IDEX_Bubble), 32'd0);
    chk("rs_mid.stall_cnt", 32'(Stall_Cnt), 32'd0);
    check_perf("rs_mid");
    @(posedge clk); #1;
    reset = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); run_cycle("rs_after");

    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0,
             $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
             $urandom_range(0, 2) == 0, $urandom_range(0, 3), $urandom_range(0, 5) == 0);
      run_cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
